// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared definitions for the unified memory-port arbiter:
//             FSM state encoding, port-owner select codes, the fixed
//             instruction-fetch byte-enable pattern and the grant helper.
//  Revision : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    // FSM state encoding
    localparam arb_state_t c_st_idle    = 2'd0;
    localparam arb_state_t c_st_busy_if = 2'd1;
    localparam arb_state_t c_st_busy_dm = 2'd2;
    localparam arb_state_t c_st_done    = 2'd3;

    // Port owner codes (drive mem_sel and the steering muxes)
    localparam logic c_sel_if = 1'b0;
    localparam logic c_sel_dm = 1'b1;

    // Instruction fetch always reads a full word
    localparam logic [3:0] c_if_be = 4'hF;

    // Picks the owner for a grant. On a tie, round-robin hands the port to
    // whichever side did not win last time; otherwise data access wins.
    function automatic logic arb_pick(
        input logic if_req,
        input logic dm_req,
        input logic rr_en,
        input logic last_gnt
    );
        if (if_req && dm_req) begin
            return rr_en ? ~last_gnt : c_sel_dm;
        end
        return dm_req ? c_sel_dm : c_sel_if;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundles the IF requester, DM requester and memory-port
//             signals of the arbiter.
//  Modports : master - the arbiter (drives done/rdata/stall and the port)
//             slave  - the surrounding CPU and memory (drive requests, ack)
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    // Data access requester
    logic          dm_req;
    logic          dm_we;
    logic [3:0]    dm_be;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;
    logic          dm_stall;
    // Unified memory port
    logic          mem_req;
    logic          mem_sel;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    // Status
    logic          bus_err;

    modport master (
        input  if_req, if_addr,
        output if_done, if_rdata, if_stall,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_done, dm_rdata, dm_stall,
        output mem_req, mem_sel, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output bus_err
    );

    modport slave (
        output if_req, if_addr,
        input  if_done, if_rdata, if_stall,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_done, dm_rdata, dm_stall,
        input  mem_req, mem_sel, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_timeout
//  Purpose  : Wait counter for a memory-port transaction. Counts cycles
//             without an ack and flags expiry on the last allowed cycle.
//  Ports    : clk       system clock
//             rst_n     synchronous reset, active low
//             i_clear   force the counter to zero (outside a transaction)
//             i_enable  advance the counter (busy, no ack this cycle)
//             o_expire  counter sits at TIMEOUT-1
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb_timeout #(
    parameter int TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);
    localparam int                 c_cnt_w = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is qualified with "no ack" by the owner of the FSM
    assign o_expire = (r_count == c_last);
endmodule
`default_nettype wire

// File: rtl/mux2_32.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_32
//  Purpose  : 2:1 multiplexer cell (32 bits by default).
//  Ports    : i_sel  select, 0 -> i_d0, 1 -> i_d1
//             i_d0   data input 0
//             i_d1   data input 1
//             o_y    selected data
//  Revision : 1.0  initial release
// ============================================================================
module mux2_32 #(
    parameter int WIDTH = 32
) (
    input  wire logic             i_sel,
    input  wire logic [WIDTH-1:0] i_d0,
    input  wire logic [WIDTH-1:0] i_d1,
    output logic      [WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares the single unified memory port between instruction
//             fetch (IF) and data access (DM). Arbitrates, latches the
//             winning request onto the port, runs the req/ack handshake,
//             returns read data and produces the IF/DM stall signals.
//  Ports    : clk    system clock (rising edge)
//             rst_n  synchronous reset, active low
//             bus    mem_port_arbiter_if.master - requesters, port, bus_err
//  Config   : ARB_RR_EN  defined   -> round-robin on ties (last_gnt register)
//                        undefined -> fixed DM-over-IF priority
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    mem_port_arbiter_if.master      bus
);

    arb_state_t    r_state;
    logic          r_mem_req;
    logic          r_mem_sel;
    logic          r_mem_we;
    logic [3:0]    r_mem_be;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic          r_bus_err;

    logic          w_grant;
    logic          w_gnt_sel;
    logic          w_busy;
    logic          w_expire;
    logic [AW-1:0] w_addr_nxt;
    logic [DW-1:0] w_wdata_nxt;

    // Grants are only made from IDLE; DONE deliberately skips arbitration so
    // requesters have a cycle to drop or renew their request.
    assign w_grant = (r_state == c_st_idle) && (bus.if_req || bus.dm_req);
    assign w_busy  = (r_state == c_st_busy_if) || (r_state == c_st_busy_dm);

`ifdef ARB_RR_EN
    logic r_last_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gnt <= c_sel_if;
        end else if (w_grant) begin
            r_last_gnt <= w_gnt_sel;
        end
    end

    assign w_gnt_sel = arb_pick(bus.if_req, bus.dm_req, 1'b1, r_last_gnt);
`else
    assign w_gnt_sel = arb_pick(bus.if_req, bus.dm_req, 1'b0, c_sel_if);
`endif

    // Steering is driven by the owner being granted this cycle, which is the
    // value mem_sel takes from the next cycle on. IF never writes, so its
    // write-data leg is tied to zero.
    mux2_32 #(.WIDTH(AW)) u_addr_mux (
        .i_sel (w_gnt_sel),
        .i_d0  (bus.if_addr),
        .i_d1  (bus.dm_addr),
        .o_y   (w_addr_nxt)
    );

    mux2_32 #(.WIDTH(DW)) u_wdata_mux (
        .i_sel (w_gnt_sel),
        .i_d0  ({DW{1'b0}}),
        .i_d1  (bus.dm_wdata),
        .o_y   (w_wdata_nxt)
    );

    // Counter is held at zero outside BUSY and only advances on no-ack cycles
    mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (~w_busy),
        .i_enable (w_busy & ~bus.mem_ack),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_mem_req   <= 1'b0;
            r_mem_sel   <= c_sel_if;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // A stray mem_ack here is simply not looked at
                    if (w_grant) begin
                        r_state     <= (w_gnt_sel == c_sel_dm) ? c_st_busy_dm : c_st_busy_if;
                        r_mem_req   <= 1'b1;
                        r_mem_sel   <= w_gnt_sel;
                        r_mem_we    <= (w_gnt_sel == c_sel_dm) ? bus.dm_we : 1'b0;
                        r_mem_be    <= (w_gnt_sel == c_sel_dm) ? bus.dm_be : c_if_be;
                        r_mem_addr  <= w_addr_nxt;
                        r_mem_wdata <= w_wdata_nxt;
                    end
                end

                c_st_busy_if, c_st_busy_dm: begin
                    // An ack on the final counted cycle still completes normally
                    if (bus.mem_ack) begin
                        if (r_state == c_st_busy_dm) begin
                            r_dm_rdata <= bus.mem_rdata;
                        end else begin
                            r_if_rdata <= bus.mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                        r_state   <= c_st_done;
                    end else if (w_expire) begin
                        if (r_state == c_st_busy_dm) begin
                            r_dm_rdata <= '0;
                        end else begin
                            r_if_rdata <= '0;
                        end
                        r_bus_err <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= c_st_done;
                    end
                end

                c_st_done: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state   <= c_st_idle;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Done pulses are decoded from DONE, so a reset that lands mid-transaction
    // can never produce one.
    assign bus.if_done   = (r_state == c_st_done) && (r_mem_sel == c_sel_if);
    assign bus.dm_done   = (r_state == c_st_done) && (r_mem_sel == c_sel_dm);
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.if_stall  = bus.if_req & ~bus.if_done;
    assign bus.dm_stall  = bus.dm_req & ~bus.dm_done;

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_sel   = r_mem_sel;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. A table of single
//             transactions with hand-computed results, followed by directed
//             sequences for ties, stray acks, timeout and mid-transaction
//             reset. Build with ARB_RR_EN to exercise round-robin.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_be     = 4'h0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction from a single requester. Acks on busy cycle ack_dly
    // (or holds ack high throughout when ack_hold is set). Latency counts the
    // request cycle as cycle 1.
    task automatic run_txn(
        input  logic        dm,
        input  logic        we,
        input  logic [3:0]  be,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  int          ack_dly,
        input  logic [31:0] rdata,
        input  logic        ack_hold,
        input  int          ncyc,
        output int          lat,
        output logic [31:0] got,
        output int          dcnt,
        output logic        port_ok,
        output logic        stall_ok
    );
        int   busy;
        logic req_now;
        logic done_now;
        busy = 0; lat = 0; got = '0; dcnt = 0; port_ok = 1'b1; stall_ok = 1'b1;
        if (dm) begin
            bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_be = be;
            bus.dm_addr = addr; bus.dm_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        bus.mem_ack   = ack_hold;
        bus.mem_rdata = rdata;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            bus.mem_ack = ack_hold;
            req_now  = dm ? bus.dm_req  : bus.if_req;
            done_now = dm ? bus.dm_done : bus.if_done;
            if ((dm ? bus.dm_stall : bus.if_stall) !== (req_now & ~done_now)) stall_ok = 1'b0;
            if ((dm ? bus.if_stall : bus.dm_stall) !== 1'b0) stall_ok = 1'b0;
            if ((dm ? bus.if_done : bus.dm_done) !== 1'b0) port_ok = 1'b0;
            if (done_now) begin
                dcnt++;
                if (dcnt == 1) begin
                    lat = c + 2;
                    got = dm ? bus.dm_rdata : bus.if_rdata;
                end
                if (bus.mem_req !== 1'b0) port_ok = 1'b0;
                if (dm) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
            end
            if (bus.mem_req) begin
                if (bus.mem_sel !== dm || bus.mem_we !== (dm ? we : 1'b0) ||
                    bus.mem_be !== (dm ? be : 4'hF) || bus.mem_addr !== addr ||
                    (dm && bus.mem_wdata !== wdata)) port_ok = 1'b0;
                if (busy == ack_dly) bus.mem_ack = 1'b1;
                busy++;
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    typedef struct {
        logic        dm;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] rdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          lat;
        logic [31:0] got;
        int          dcnt;
        logic        pok;
        logic        sok;
        int          ord[8];
        int          n;
        int          if_cnt;
        int          dm_cnt;
        int          bad;
        logic        stall_seen;

        //            dm    we    be     addr          wdata          dly rdata          lat rdata-out
        vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,         0, 32'h8C01_0004, 3, 32'h8C01_0004};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_2000, 32'h0000_CAFE, 5, 32'h1111_2222, 8, 32'h1111_2222};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_3004, 32'h0,         2, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0,         1, 32'h1234_5678, 4, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 4'h4, 32'h0000_0040, 32'h0,         0, 32'hA5A5_A5A5, 3, 32'hA5A5_A5A5};

        do_reset();

        // Reset state
        chk("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_sel",   {31'd0, bus.mem_sel}, 32'd0);
        chk("rst_mem_we",    {31'd0, bus.mem_we},  32'd0);
        chk("rst_mem_be",    {28'd0, bus.mem_be},  32'd0);
        chk("rst_mem_addr",  bus.mem_addr,         32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,        32'd0);
        chk("rst_if_rdata",  bus.if_rdata,         32'd0);
        chk("rst_dm_rdata",  bus.dm_rdata,         32'd0);
        chk("rst_dones",     {30'd0, bus.if_done, bus.dm_done}, 32'd0);
        chk("rst_bus_err",   {31'd0, bus.bus_err}, 32'd0);

        // Single-transaction table
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].dm, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                    vecs[i].ack_dly, vecs[i].rdata, 1'b0, vecs[i].ack_dly + 6,
                    lat, got, dcnt, pok, sok);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_done_count", i), dcnt, 32'd1);
            chk($sformatf("vec%0d_port", i), {31'd0, pok}, 32'd1);
            chk($sformatf("vec%0d_stall", i), {31'd0, sok}, 32'd1);
        end
        chk("no_bus_err_after_table", {31'd0, bus.bus_err}, 32'd0);

        // Stray ack held through IDLE, BUSY and DONE: exactly one completion
        run_txn(1'b0, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 1000, 32'h0000_55AA, 1'b1, 7,
                lat, got, dcnt, pok, sok);
        chk("stray_latency",    lat,  32'd3);
        chk("stray_rdata",      got,  32'h0000_55AA);
        chk("stray_done_count", dcnt, 32'd1);
        bus.mem_ack = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.mem_req || bus.if_done || bus.dm_done) bad++;
        end
        bus.mem_ack = 1'b0;
        chk("stray_idle_quiet", bad, 32'd0);

        // Tie, both served once: DM first, IF keeps stalling meanwhile
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0200;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h0000_0044; bus.dm_be = 4'hF;
        n = 0; if_cnt = 0; dm_cnt = 0; stall_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (c == 0) stall_seen = bus.if_stall;
            if (bus.dm_done) begin
                if (n < 8) ord[n] = 1;
                n++; dm_cnt++; bus.dm_req = 1'b0;
            end
            if (bus.if_done) begin
                if (n < 8) ord[n] = 0;
                n++; if_cnt++; bus.if_req = 1'b0;
            end
            if (bus.mem_req) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = bus.mem_sel ? 32'h0000_00D0 : 32'h0000_0010;
            end
        end
        bus.mem_ack = 1'b0;
        chk("tie_if_stalls",  {31'd0, stall_seen}, 32'd1);
        chk("tie_dm_once",    dm_cnt, 32'd1);
        chk("tie_if_once",    if_cnt, 32'd1);
        chk("tie_first_dm",   (n > 1) ? ord[0] : -1, 32'd1);
        chk("tie_second_if",  (n > 1) ? ord[1] : -1, 32'd0);
        chk("tie_if_rdata",   bus.if_rdata, 32'h0000_0010);
        chk("tie_dm_rdata",   bus.dm_rdata, 32'h0000_00D0);

        // Four repeated ties with both requesters renewing continuously
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h0000_0800; bus.dm_be = 4'hF;
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.dm_done || bus.if_done) begin
                ord[n] = bus.dm_done ? 1 : 0;
                n++;
                if (n == 4) begin
                    bus.if_req = 1'b0;
                    bus.dm_req = 1'b0;
                end
            end
            if (bus.mem_req) bus.mem_ack = 1'b1;
        end
        bus.mem_ack = 1'b0;
        chk("renew_count", n, 32'd4);
`ifdef ARB_RR_EN
        chk("renew_order0", ord[0], 32'd1);
        chk("renew_order1", ord[1], 32'd0);
        chk("renew_order2", ord[2], 32'd1);
        chk("renew_order3", ord[3], 32'd0);
`else
        chk("renew_order0", ord[0], 32'd1);
        chk("renew_order1", ord[1], 32'd1);
        chk("renew_order2", ord[2], 32'd1);
        chk("renew_order3", ord[3], 32'd1);
`endif
        repeat (2) @(negedge clk);

        // Timeout: no ack at all
        run_txn(1'b0, 1'b0, 4'hF, 32'h0000_0500, 32'h0, 1000, 32'hFFFF_FFFF, 1'b0, TIMEOUT + 6,
                lat, got, dcnt, pok, sok);
        chk("timeout_latency",    lat,  TIMEOUT + 2);
        chk("timeout_rdata_zero", got,  32'd0);
        chk("timeout_done_count", dcnt, 32'd1);
        chk("timeout_port",       {31'd0, pok}, 32'd1);
        chk("timeout_bus_err",    {31'd0, bus.bus_err}, 32'd1);
        run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0, 0, 32'h0000_7777, 1'b0, 6,
                lat, got, dcnt, pok, sok);
        chk("after_timeout_rdata",  got, 32'h0000_7777);
        chk("bus_err_sticky",       {31'd0, bus.bus_err}, 32'd1);
        do_reset();
        chk("bus_err_cleared",      {31'd0, bus.bus_err}, 32'd0);

        // Reset while in BUSY_DM, then a late ack
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h0000_0080;
        for (int c = 0; c < 10 && !bus.mem_req; c++) @(negedge clk);
        chk("midrst_busy_reached", {30'd0, bus.mem_req, bus.mem_sel}, 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("midrst_no_done", {31'd0, bus.dm_done}, 32'd0);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0000_0BAD;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.dm_done || bus.if_done || bus.mem_req) bad++;
        end
        chk("late_ack_ignored", bad, 32'd0);
        chk("late_ack_rdata",   bus.dm_rdata, 32'd0);
        run_txn(1'b0, 1'b0, 4'hF, 32'h0000_0700, 32'h0, 0, 32'h0000_0321, 1'b0, 6,
                lat, got, dcnt, pok, sok);
        chk("post_reset_latency", lat, 32'd3);
        chk("post_reset_rdata",   got, 32'h0000_0321);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
